mem_ctrl: RTL and testbench

Arbitrates the single byte-wide external RAM port between the instruction-fetch path (icache line/word fill) and the load/store path. It grants one requester at a time and serialises each request into 1/2/4 byte-wide RAM cycles. It assembles read bytes into little-endian words and returns them with a one-cycle ready pulse. It sits between the icache / load-store buffer and the top-level RAM pins, and obeys the global `rdy` stall and the ROB-cleaner flush.

---
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-wide external RAM arbiter: grants the data port or the instruction fetch,
// serialises each request into 1/2/4 RAM cycles and returns little-endian words.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_rdy_o,
  output logic [31:0]       ic_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_len_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_rdy_o,
  output logic [31:0]       d_rdata_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);

  typedef enum logic [1:0] {IDLE, IRD, DRD, DWR} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        nbytes, nbytes_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [31:0]       rbuf_q, rbuf_n;

  logic              ic_rdy_n, d_rdy_n, mem_wr_n;
  logic [31:0]       ic_data_n, d_rdata_n;
  logic [7:0]        mem_dout_n;
  logic [ADDR_W-1:0] mem_a_n;

  logic [2:0]        req_bytes;
  logic              d_go, i_go;
  logic [1:0]        rd_idx;
  logic [31:0]       rbuf_fill;
  logic [ADDR_W-1:0] addr_next;

  // A requester still showing its ready pulse has already been served this cycle.
  assign d_go      = d_req_i && !d_rdy_o && (d_we_i || !clr_i);
  assign i_go      = ic_req_i && !ic_rdy_o && !clr_i;
  assign req_bytes = (d_len_i == 2'd0) ? 3'd1 : (d_len_i == 2'd1) ? 3'd2 : 3'd4;
  // cnt runs 1..4 while reading, so the byte slot is cnt-1 taken modulo 4.
  assign rd_idx    = cnt[1:0] - 2'd1;
  assign addr_next = addr_q + ADDR_W'(cnt);

  always_comb begin
    rbuf_fill = rbuf_q;
    rbuf_fill[{rd_idx, 3'b000} +: 8] = mem_din_i;
  end

  always_comb begin
    // NOTE: every next-value gets a default before the case so no path infers a latch.
    state_n    = state;
    cnt_n      = cnt;
    nbytes_n   = nbytes;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    rbuf_n     = rbuf_q;
    ic_rdy_n   = 1'b0;
    d_rdy_n    = 1'b0;
    ic_data_n  = ic_data_o;
    d_rdata_n  = d_rdata_o;
    mem_dout_n = mem_dout_o;
    mem_a_n    = mem_a_o;
    mem_wr_n   = mem_wr_o;

    unique case (state)
      IDLE: begin
        if (d_go) begin
          state_n    = d_we_i ? DWR : DRD;
          cnt_n      = 3'd1;
          nbytes_n   = req_bytes;
          addr_n     = d_addr_i;
          wdata_n    = d_wdata_i;
          rbuf_n     = '0;
          mem_a_n    = d_addr_i;
          mem_wr_n   = d_we_i;
          mem_dout_n = d_wdata_i[7:0];
        end else if (i_go) begin
          state_n    = IRD;
          cnt_n      = 3'd1;
          nbytes_n   = 3'd4;
          addr_n     = ic_addr_i;
          rbuf_n     = '0;
          mem_a_n    = ic_addr_i;
          mem_wr_n   = 1'b0;
          mem_dout_n = 8'h00;
        end
      end

      IRD, DRD: begin
        if (clr_i) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          mem_a_n = '0;
        end else if (cnt < nbytes) begin
          rbuf_n  = rbuf_fill;
          mem_a_n = addr_next;
          cnt_n   = cnt + 3'd1;
        end else begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          mem_a_n = '0;
          if (state == IRD) begin
            ic_rdy_n  = 1'b1;
            ic_data_n = rbuf_fill;
          end else begin
            d_rdy_n   = 1'b1;
            d_rdata_n = rbuf_fill;
          end
        end
      end

      DWR: begin
        // Committed stores ignore the flush and always run to completion.
        if (cnt < nbytes) begin
          mem_a_n    = addr_next;
          mem_dout_n = wdata_q[{cnt[1:0], 3'b000} +: 8];
          cnt_n      = cnt + 3'd1;
        end else begin
          state_n  = IDLE;
          cnt_n    = 3'd0;
          mem_a_n  = '0;
          mem_wr_n = 1'b0;
          d_rdy_n  = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      ic_rdy_o   <= 1'b0;
      ic_data_o  <= '0;
      d_rdy_o    <= 1'b0;
      d_rdata_o  <= '0;
      mem_dout_o <= '0;
      mem_a_o    <= '0;
      mem_wr_o   <= 1'b0;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      nbytes     <= nbytes_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rbuf_q     <= rbuf_n;
      ic_rdy_o   <= ic_rdy_n;
      ic_data_o  <= ic_data_n;
      d_rdy_o    <= d_rdy_n;
      d_rdata_o  <= d_rdata_n;
      mem_dout_o <= mem_dout_n;
      mem_a_o    <= mem_a_n;
      mem_wr_o   <= mem_wr_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and random transactions against mem_ctrl, with a byte-array RAM device
// and a shadow memory that predicts load data and store results.
module tb_mem_ctrl;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst, rdy, clr_i;
  logic              ic_req_i, ic_rdy_o;
  logic [ADDR_W-1:0] ic_addr_i;
  logic [31:0]       ic_data_o;
  logic              d_req_i, d_we_i, d_rdy_o;
  logic [1:0]        d_len_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i, d_rdata_o;
  logic [7:0]        mem_din_i, mem_dout_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_wr_o;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_len_i(d_len_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdy_o(d_rdy_o), .d_rdata_o(d_rdata_o),
    .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o)
  );

  logic [7:0]  ram    [0:1023];
  logic [7:0]  shadow [0:1023];
  logic        init_req;
  int          wr_edges = 0;
  int          exp_writes = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ic, exp_d;
  bit          d_known;

  // RAM device: read data follows the address combinationally, writes land at the edge.
  assign mem_din_i = ram[mem_a_o[9:0]];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) ram[i] <= shadow[i];
    end else if (mem_wr_o === 1'b1) begin
      ram[mem_a_o[9:0]] <= mem_dout_o;
      wr_edges <= wr_edges + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic post_check;
    tick;
    check("ic_rdy_drop", ic_rdy_o, 32'h0);
    check("d_rdy_drop", d_rdy_o, 32'h0);
    check("ic_data_hold", ic_data_o, exp_ic);
    if (d_known) check("d_data_hold", d_rdata_o, exp_d);
    check("idle_addr", mem_a_o, 32'h0);
    check("idle_wr", mem_wr_o, 32'h0);
  endtask

  // One complete transaction; the grant happens at the first edge after the call.
  task automatic run_txn(input bit is_d, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold_clr, input int stall_at, input int stall_len);
    int          n;
    logic [31:0] exp, a, snap_a;
    logic        snap_wr;
    n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    exp = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (we) shadow[a[9:0]] = wdata[8*i +: 8];
      else    exp = exp | (32'(shadow[a[9:0]]) << (8*i));
    end
    if (we) exp_writes += n;

    if (is_d) begin
      d_req_i = 1'b1; d_we_i = we; d_len_i = len; d_addr_i = addr; d_wdata_i = wdata;
    end else begin
      ic_req_i = 1'b1; ic_addr_i = addr;
    end
    clr_i = hold_clr;

    for (int i = 1; i <= n + 1; i++) begin
      if (i == stall_at) begin
        snap_a  = mem_a_o;
        snap_wr = mem_wr_o;
        rdy     = 1'b0;
        repeat (stall_len) begin
          tick;
          check("stall_addr", mem_a_o, snap_a);
          check("stall_wr", mem_wr_o, snap_wr);
          check("stall_rdy", is_d ? d_rdy_o : ic_rdy_o, 32'h0);
        end
        rdy = 1'b1;
      end
      tick;
      if (i <= n) begin
        check("byte_addr", mem_a_o, addr + 32'(i - 1));
        check("byte_wr", mem_wr_o, 32'(we));
        if (we) check("byte_dout", mem_dout_o, 32'(wdata[8*(i-1) +: 8]));
        check("early_rdy", is_d ? d_rdy_o : ic_rdy_o, 32'h0);
      end else begin
        check("done_rdy", is_d ? d_rdy_o : ic_rdy_o, 32'h1);
        check("done_addr", mem_a_o, 32'h0);
        check("done_wr", mem_wr_o, 32'h0);
        if (!we) check("done_data", is_d ? d_rdata_o : ic_data_o, exp);
      end
    end

    if (is_d) d_req_i = 1'b0;
    else      ic_req_i = 1'b0;
    clr_i = 1'b0;

    if (we) begin
      d_known = 1'b0;
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        check("ram_byte", ram[a[9:0]], shadow[a[9:0]]);
      end
    end else if (is_d) begin
      exp_d   = exp;
      d_known = 1'b1;
    end else begin
      exp_ic = exp;
    end
  endtask

  initial begin
    int          bad;
    bit          r_d, r_we;
    logic [1:0]  r_len;
    int          r_stall;

    for (int i = 0; i < 1024; i++) shadow[i] = 8'($urandom);
    shadow[10'h100] = 8'h13; shadow[10'h101] = 8'h05;
    shadow[10'h102] = 8'h10; shadow[10'h103] = 8'h00;
    shadow[10'h3FF] = 8'h80;

    rst = 1'b0; rdy = 1'b0; clr_i = 1'b0; init_req = 1'b1;
    ic_req_i = 1'b0; ic_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_len_i = 2'd0; d_addr_i = '0; d_wdata_i = '0;
    tick;
    init_req = 1'b0;
    tick;
    check("rst_mem_a", mem_a_o, 32'h0);
    check("rst_mem_wr", mem_wr_o, 32'h0);
    check("rst_mem_dout", mem_dout_o, 32'h0);
    check("rst_ic_rdy", ic_rdy_o, 32'h0);
    check("rst_d_rdy", d_rdy_o, 32'h0);
    check("rst_ic_data", ic_data_o, 32'h0);
    check("rst_d_rdata", d_rdata_o, 32'h0);
    exp_ic = 32'h0; exp_d = 32'h0; d_known = 1'b1;
    rst = 1'b1; rdy = 1'b1;

    // Instruction fetch of a known word.
    run_txn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 0, 0);
    check("fetch_word", ic_data_o, 32'h00100513);
    post_check;

    // Simultaneous requests: the store wins, the fetch follows straight after.
    ic_req_i = 1'b1; ic_addr_i = 32'h100;
    run_txn(1'b1, 1'b1, 2'd1, 32'h20, 32'hA1B2C3D4, 1'b0, 0, 0);
    check("store_b0", ram[10'h020], 32'hD4);
    check("store_b1", ram[10'h021], 32'hC3);
    run_txn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 0, 0);
    post_check;

    // Loads at the top of the address space, including the wrap to 0.
    run_txn(1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 0);
    check("load_top", d_rdata_o, 32'h00000080);
    post_check;
    run_txn(1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 0);
    post_check;

    // Flush two edges into a fetch, with the request still held during the flush.
    ic_req_i = 1'b1; ic_addr_i = 32'h200;
    tick;
    check("flush_a0", mem_a_o, 32'h200);
    tick;
    check("flush_a1", mem_a_o, 32'h201);
    clr_i = 1'b1;
    tick;
    check("flush_abort_addr", mem_a_o, 32'h0);
    check("flush_abort_rdy", ic_rdy_o, 32'h0);
    tick;
    check("flush_no_grant", mem_a_o, 32'h0);
    check("flush_no_rdy", ic_rdy_o, 32'h0);
    ic_req_i = 1'b0; clr_i = 1'b0;
    post_check;

    // A 4-byte store under a continuous flush still completes.
    run_txn(1'b1, 1'b1, 2'd2, 32'h40, $urandom, 1'b1, 0, 0);
    post_check;

    // Three-cycle stall starting at the third edge of a fetch.
    run_txn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 3, 3);
    post_check;

    // Reset one edge into a store (with rdy low, reset still wins).
    d_req_i = 1'b1; d_we_i = 1'b1; d_len_i = 2'd1; d_addr_i = 32'h60; d_wdata_i = 32'h00005566;
    shadow[10'h060] = 8'h66;
    exp_writes += 1;
    tick;
    check("rst_store_wr", mem_wr_o, 32'h1);
    rst = 1'b0; rdy = 1'b0; d_req_i = 1'b0;
    tick;
    check("rst_store_wr_off", mem_wr_o, 32'h0);
    check("rst_store_addr", mem_a_o, 32'h0);
    check("rst_store_rdy", d_rdy_o, 32'h0);
    rst = 1'b1; rdy = 1'b1;
    exp_ic = 32'h0; exp_d = 32'h0; d_known = 1'b1;
    post_check;
    check("rst_store_b0", ram[10'h060], 32'h66);
    check("rst_store_b1", ram[10'h061], 32'(shadow[10'h061]));

    // Random mix of fetches, loads and stores.
    for (int t = 0; t < 40; t++) begin
      r_d     = 1'($urandom_range(0, 1));
      r_we    = r_d ? 1'($urandom_range(0, 1)) : 1'b0;
      r_len   = r_d ? 2'($urandom_range(0, 3)) : 2'd2;
      r_stall = r_we ? 0 : $urandom_range(0, 2);
      run_txn(r_d, r_we, r_len, $urandom, $urandom, r_we ? 1'($urandom_range(0, 1)) : 1'b0,
              r_stall, $urandom_range(1, 3));
      post_check;
    end

    check("write_count", wr_edges, exp_writes);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== shadow[i]) bad++;
    check("ram_image", bad, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
